// File: rtl/icache_dm_fetch_if.sv
// Fetch-side and backing-memory-side signal bundle for the direct-mapped I-cache.
// The slave modport is the cache's view. The master modport is the view of the
// surrounding core/memory environment that drives the cache.
interface icache_dm_fetch_if;
  logic [31:0] imem_A;
  logic        imem_read;
  logic        imem_ready;
  logic [31:0] imem_RD;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  imem_A, imem_read, mem_ack, mem_rdata,
    output imem_ready, imem_RD, mem_req, mem_addr
  );

  modport master (
    output imem_A, imem_read, mem_ack, mem_rdata,
    input  imem_ready, imem_RD, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_dm_fetch.sv
// Direct-mapped, read-only instruction cache in front of a word-wide backing memory.
// Hits return data combinationally. A miss refills the whole line in ascending beat
// order over a req/ack handshake, with imem_ready held low so that fetch stalls.
module icache_dm_fetch #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  icache_dm_fetch_if.slave  bus,
  input  logic              flush,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int OB    = 2 + OFF_W;
  localparam int TAG_W = 32 - OB - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state, state_nxt;

  // Lookup address fields
  logic [OFF_W-1:0] off_a;
  logic [IDX_W-1:0] idx_a;
  logic [TAG_W-1:0] tag_a;
  logic [1:0]       unused_addr_lsb;

  // Line storage: valid bits are reset, tags and data are not
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*LINE_WORDS];

  // Refill bookkeeping
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic [OFF_W-1:0] beat;
  logic             drop;

  logic hit;
  logic start_miss;
  logic beat_ack;
  logic final_ack;

  assign off_a           = bus.imem_A[OB-1:2];
  assign idx_a           = bus.imem_A[OB+IDX_W-1:OB];
  assign tag_a           = bus.imem_A[31:OB+IDX_W];
  assign unused_addr_lsb = bus.imem_A[1:0];

  assign hit        = valid_q[idx_a] && (tag_mem[idx_a] == tag_a);
  // Flush wins over a miss in IDLE, so no refill starts on a flush cycle.
  assign start_miss = (state == IDLE) && bus.imem_read && !hit && !flush;
  // Acks are only meaningful while a refill is outstanding.
  assign beat_ack   = (state == REFILL) && bus.mem_ack;
  assign final_ack  = beat_ack && (beat == LAST_BEAT);

  assign bus.imem_RD = data_mem[{idx_a, off_a}];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: enter REFILL on a miss, leave on the last beat's ack
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_miss) state_nxt = REFILL;
      REFILL:  if (final_ack)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: a hit is only reported while idle, never during or on the way out of a refill
  always_comb begin
    bus.imem_ready = (state == IDLE) && bus.imem_read && hit;
  end

  // Control registers: request/address sequencing, beat count, drop flag, valid bits, miss counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
      beat         <= '0;
      drop         <= 1'b0;
      valid_q      <= '0;
      miss_cnt     <= '0;
    end else begin
      if (start_miss) begin
        bus.mem_req  <= 1'b1;
        bus.mem_addr <= {bus.imem_A[31:OB], {OB{1'b0}}};
        beat         <= '0;
        if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + 1'b1;
      end else if (beat_ack) begin
        bus.mem_addr <= bus.mem_addr + 32'd4;
        beat         <= beat + 1'b1;
        if (final_ack) bus.mem_req <= 1'b0;
      end

      // A flush during refill still lets the line finish but marks it to be left invalid.
      if (state != REFILL || final_ack) drop <= 1'b0;
      else if (flush)                   drop <= 1'b1;

      // Flush on the final-ack edge overrides the line's valid write.
      if (flush)          valid_q           <= '0;
      else if (final_ack) valid_q[miss_idx] <= !drop;
    end
  end

  // Data path: capture the miss line coordinates, then write beats and the tag as they arrive
  always_ff @(posedge clk) begin
    if (start_miss) begin
      miss_idx <= idx_a;
      miss_tag <= tag_a;
    end
    if (beat_ack) data_mem[{miss_idx, beat}] <= bus.mem_rdata;
    if (final_ack) tag_mem[miss_idx] <= miss_tag;
  end

endmodule
